alu_issue_unit: RTL

Sequential issue/commit controller that drives the existing combinational MIPS ALU. It is the RTL initiator on the ALU's instruction/operand interface. The block accepts one 32-bit instruction per valid/ready handshake and reads rs/rt from an internal register file. It then presents instruction and operands to the ALU, samples result and flags, and commits to the register file or raises branch, memory-address or trap pulses. It sits between the future fetch stage and the ALU.

---
 rtl/alu_pkg.sv | 89 ++++++++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_issue_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/funct constants, FSM encoding, flag indices and decode helper
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside wb_flags = {zero, negative, overflow}
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

    typedef struct packed {
        logic       legal;
        logic       has_dest;
        logic [4:0] dest;
        logic       ovf_check;  // only add, sub, addi trap on overflow
        logic       is_beq;
        logic       is_bne;
        logic       is_mem;
        logic       is_store;
    } decode_t;

    function automatic decode_t decode_instr(input logic [5:0] opcode,
                                             input logic [5:0] funct,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
        decode_t d;
        d = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB: begin
                        d.legal = 1'b1; d.has_dest = 1'b1; d.dest = rd; d.ovf_check = 1'b1;
                    end
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV,
                    FN_SLT, FN_SLTU: begin
                        d.legal = 1'b1; d.has_dest = 1'b1; d.dest = rd;
                    end
                    default: d = '0;
                endcase
            end
            OP_ADDI: begin
                d.legal = 1'b1; d.has_dest = 1'b1; d.dest = rt; d.ovf_check = 1'b1;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                d.legal = 1'b1; d.has_dest = 1'b1; d.dest = rt;
            end
            OP_BEQ: begin d.legal = 1'b1; d.is_beq = 1'b1; end
            OP_BNE: begin d.legal = 1'b1; d.is_bne = 1'b1; end
            OP_LW:  begin d.legal = 1'b1; d.is_mem = 1'b1; end
            OP_SW:  begin d.legal = 1'b1; d.is_mem = 1'b1; d.is_store = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 32x32 register file, two read ports plus debug port, one write port
// Ports: clk, rst_n (async clear), ra/rb read ports, dbg read port, we/waddr/wdata write port.
module alu_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is hard-wired to zero on every read port
    assign ra_data  = (ra_addr  == 5'd0) ? 32'd0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == 5'd0) ? 32'd0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue/commit controller driving an external combinational MIPS ALU
// Ports: in_valid/in_ready/in_instr accept side; alu_* operands out, result/flags in;
// wb_* commit pulse; br_taken, mem_*, ovf_trap, ill_trap outcome pulses; dbg_addr/dbg_data.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_rega,
    output logic [31:0] alu_regb,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [2:0]  wb_flags,
    output logic        br_taken,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        ovf_trap,
    output logic        ill_trap,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [1:0]  state;
    logic [31:0] instr_q;
    logic [31:0] rega_q;
    logic [31:0] regb_q;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [2:0]  alu_flags;
    decode_t     dec;
    logic        ovf_hit;
    logic        commit;

    // Operands are read straight from the offered instruction so they can be latched at accept
    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (in_instr[25:21]),
        .ra_data  (rs_data),
        .rb_addr  (in_instr[20:16]),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       ((state == ST_EXEC) && commit),
        .waddr    (dec.dest),
        .wdata    (alu_result)
    );

    assign in_ready  = (state == ST_IDLE);
    assign alu_instr = instr_q;
    assign alu_rega  = rega_q;
    assign alu_regb  = regb_q;

    always_comb begin
        alu_flags = '0;
        alu_flags[FLAG_ZERO] = alu_zero;
        alu_flags[FLAG_NEG]  = alu_negative;
        alu_flags[FLAG_OVF]  = alu_overflow;
    end

    assign dec     = decode_instr(instr_q[31:26], instr_q[5:0], instr_q[20:16], instr_q[15:11]);
    assign ovf_hit = dec.ovf_check && alu_overflow;
    assign commit  = dec.legal && dec.has_dest && !ovf_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            rega_q    <= '0;
            regb_q    <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            wb_flags  <= '0;
            br_taken  <= 1'b0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ovf_trap  <= 1'b0;
            ill_trap  <= 1'b0;
        end else begin
            // Pulses are only ever set on the EXEC->DONE edge, so they last exactly the DONE cycle
            wb_valid  <= 1'b0;
            br_taken  <= 1'b0;
            mem_valid <= 1'b0;
            ovf_trap  <= 1'b0;
            ill_trap  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        rega_q  <= rs_data;
                        regb_q  <= rt_data;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state    <= ST_DONE;
                    wb_valid <= commit;
                    if (commit) begin
                        wb_addr  <= dec.dest;
                        wb_data  <= alu_result;
                        wb_flags <= alu_flags;
                    end
                    br_taken  <= (dec.is_beq && alu_zero) || (dec.is_bne && !alu_zero);
                    mem_valid <= dec.is_mem;
                    if (dec.is_mem) begin
                        mem_write <= dec.is_store;
                        mem_addr  <= alu_result;
                        mem_wdata <= regb_q;
                    end
                    ovf_trap <= ovf_hit;
                    ill_trap <= !dec.legal;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
